// File: rtl/regfile_hilo_pkg.sv
// -----------------------------------------------------------------------------
// regfile_hilo_pkg
// Shared architectural types for the retire-side register file:
//   word_t      - 32-bit data word
//   creg_addr_t - 5-bit GPR address
//   rf_w_t      - one GPR write request from retire (addr, wd, wen)
//   hilo_w_t    - one HI/LO update from retire (independent halves)
// -----------------------------------------------------------------------------
package regfile_hilo_pkg;

    localparam int WORD_W   = 32;
    localparam int CREG_W   = 5;
    localparam int NUM_GPR  = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CREG_W-1:0] creg_addr_t;

    typedef struct packed {
        creg_addr_t addr;
        word_t      wd;
        logic       wen;
    } rf_w_t;

    typedef struct packed {
        logic  wen_h;
        logic  wen_l;
        word_t wd_h;
        word_t wd_l;
    } hilo_w_t;

    // True when a write request targets a real (non-$0) register.
    function automatic logic gpr_write_hits(input rf_w_t w, input creg_addr_t a);
        return w.wen && (w.addr == a) && (a != '0);
    endfunction

endpackage

// File: rtl/regfile_hilo_hilo.sv
// -----------------------------------------------------------------------------
// hilo_reg
// HI/LO architectural flops with independent write enables. No forwarding:
// the outputs always show the registered value.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; clears both registers
//   wen_h  - load HI from wd_h
//   wen_l  - load LO from wd_l
//   wd_h   - new HI value
//   wd_l   - new LO value
//   hi/lo  - registered HI/LO
// -----------------------------------------------------------------------------
module hilo_reg
    import regfile_hilo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wen_h,
    input  logic  wen_l,
    input  word_t wd_h,
    input  word_t wd_l,
    output word_t hi,
    output word_t lo
);

    word_t r_hi;
    word_t r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (wen_h) begin
                r_hi <= wd_h;
            end
            if (wen_l) begin
                r_lo <= wd_l;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: rtl/regfile_hilo.sv
// -----------------------------------------------------------------------------
// regfile_hilo
// MIPS GPR file (31 x 32-bit, $0 hardwired to zero) plus HI/LO, sitting
// directly after the dual-issue retire stage.
// Parameters:
//   NREAD         - number of combinational GPR read ports
//   WRITE_THROUGH - 1: reads see a write committing this cycle
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; clears GPRs, HI and LO
//   rfw    - two GPR write requests; slot 0 wins on an address collision
//   hlw    - HI/LO update with independent enables
//   ra     - read addresses, one per port
//   rd     - read data, one per port
//   hi/lo  - registered HI/LO
// -----------------------------------------------------------------------------
module regfile_hilo
    import regfile_hilo_pkg::*;
#(
    parameter int NREAD         = 4,
    parameter bit WRITE_THROUGH = 1'b1
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  rf_w_t      [1:0]       rfw,
    input  hilo_w_t                hlw,
    input  creg_addr_t [NREAD-1:0] ra,
    output word_t      [NREAD-1:0] rd,
    output word_t                  hi,
    output word_t                  lo
);

    // Storage exists for $1..$31 only.
    word_t r_gpr [1:NUM_GPR-1];

    // Full 32-entry view with $0 tied to zero, so the read mux can index
    // directly by the 5-bit address.
    word_t w_gpr [NUM_GPR];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_GPR; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            // Slot 0 is checked first so it takes priority on a collision.
            for (int i = 1; i < NUM_GPR; i++) begin
                if (gpr_write_hits(rfw[0], creg_addr_t'(i))) begin
                    r_gpr[i] <= rfw[0].wd;
                end else if (gpr_write_hits(rfw[1], creg_addr_t'(i))) begin
                    r_gpr[i] <= rfw[1].wd;
                end
            end
        end
    end

    always_comb begin
        w_gpr[0] = '0;
        for (int i = 1; i < NUM_GPR; i++) begin
            w_gpr[i] = r_gpr[i];
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        word_t w_rd;

        if (WRITE_THROUGH) begin : g_wt
            always_comb begin
                w_rd = '0;
                if (ra[gi] != '0) begin
                    if (gpr_write_hits(rfw[0], ra[gi])) begin
                        w_rd = rfw[0].wd;
                    end else if (gpr_write_hits(rfw[1], ra[gi])) begin
                        w_rd = rfw[1].wd;
                    end else begin
                        w_rd = w_gpr[ra[gi]];
                    end
                end
            end
        end else begin : g_nwt
            always_comb begin
                w_rd = '0;
                if (ra[gi] != '0) begin
                    w_rd = w_gpr[ra[gi]];
                end
            end
        end

        assign rd[gi] = w_rd;
    end

    hilo_reg u_hilo (
        .clk   (clk),
        .reset (reset),
        .wen_h (hlw.wen_h),
        .wen_l (hlw.wen_l),
        .wd_h  (hlw.wd_h),
        .wd_l  (hlw.wd_l),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
module tb_regfile_hilo;
    import regfile_hilo_pkg::*;

    logic               clk;
    logic               reset;
    rf_w_t   [1:0]      rfw;
    hilo_w_t            hlw;
    creg_addr_t [3:0]   ra;
    word_t   [3:0]      rd_wt;
    word_t   [3:0]      rd_nw;
    word_t              hi_wt, lo_wt, hi_nw, lo_nw;

    int vectors;
    int miscompares;

    regfile_hilo #(.NREAD(4), .WRITE_THROUGH(1'b1)) dut (
        .clk(clk), .reset(reset), .rfw(rfw), .hlw(hlw), .ra(ra),
        .rd(rd_wt), .hi(hi_wt), .lo(lo_wt)
    );

    regfile_hilo #(.NREAD(4), .WRITE_THROUGH(1'b0)) dut_nwt (
        .clk(clk), .reset(reset), .rfw(rfw), .hlw(hlw), .ra(ra),
        .rd(rd_nw), .hi(hi_nw), .lo(lo_nw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle inputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int s, input logic [4:0] a, input logic [31:0] d, input logic en);
        rfw[s].addr = a;
        rfw[s].wd   = d;
        rfw[s].wen  = en;
    endtask

    task automatic clr_w();
        set_w(0, 5'd0, 32'h0, 1'b0);
        set_w(1, 5'd0, 32'h0, 1'b0);
        hlw = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        clr_w();
        ra = '0;
        tick();
        tick();
        reset = 1'b0;
        #3;
        chk("reset0_hi", hi_wt, 32'h0);
        chk("reset0_lo", lo_wt, 32'h0);

        // Fill every register (and HI/LO) with all ones.
        for (int r = 0; r < 32; r += 2) begin
            set_w(0, 5'(r), 32'hFFFF_FFFF, 1'b1);
            set_w(1, 5'(r + 1), 32'hFFFF_FFFF, 1'b1);
            hlw = '{wen_h: 1'b1, wen_l: 1'b1, wd_h: 32'hFFFF_FFFF, wd_l: 32'hFFFF_FFFF};
            tick();
        end
        clr_w();
        ra = {5'd31, 5'd17, 5'd1, 5'd0};
        #3;
        chk("fill_r31", rd_nw[3], 32'hFFFF_FFFF);
        chk("fill_r17", rd_nw[2], 32'hFFFF_FFFF);
        chk("fill_r1",  rd_nw[1], 32'hFFFF_FFFF);
        chk("fill_r0",  rd_nw[0], 32'h0);
        chk("fill_hi",  hi_wt, 32'hFFFF_FFFF);

        // Reset with a write pending: the write must be dropped.
        reset = 1'b1;
        set_w(0, 5'd4, 32'h0000_1111, 1'b1);
        hlw = '{wen_h: 1'b1, wen_l: 1'b1, wd_h: 32'h5, wd_l: 32'h6};
        tick();
        reset = 1'b0;
        clr_w();
        for (int g = 0; g < 8; g++) begin
            ra = {5'(4*g + 3), 5'(4*g + 2), 5'(4*g + 1), 5'(4*g)};
            #2;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("rst_wt_r%0d", 4*g + p), rd_wt[p], 32'h0);
                chk($sformatf("rst_nw_r%0d", 4*g + p), rd_nw[p], 32'h0);
            end
        end
        chk("rst_hi", hi_wt, 32'h0);
        chk("rst_lo", lo_wt, 32'h0);
        chk("rst_hi_nw", hi_nw, 32'h0);
        chk("rst_lo_nw", lo_nw, 32'h0);

        // Dual commit; same-cycle forwarding from both slots.
        set_w(0, 5'd3, 32'h1234_5678, 1'b1);
        set_w(1, 5'd7, 32'hDEAD_BEEF, 1'b1);
        ra = {5'd3, 5'd7, 5'd0, 5'd3};
        #3;
        chk("dual_wt_s0", rd_wt[3], 32'h1234_5678);
        chk("dual_wt_s1", rd_wt[2], 32'hDEAD_BEEF);
        chk("dual_wt_r0", rd_wt[1], 32'h0);
        chk("dual_wt_s0b", rd_wt[0], 32'h1234_5678);
        chk("dual_nw_old", rd_nw[2], 32'h0);
        tick();
        clr_w();
        #3;
        chk("dual_r3", rd_wt[3], 32'h1234_5678);
        chk("dual_r7", rd_wt[2], 32'hDEAD_BEEF);
        chk("dual_r0", rd_wt[1], 32'h0);
        chk("dual_r3b", rd_wt[0], 32'h1234_5678);
        chk("dual_nw_r7", rd_nw[2], 32'hDEAD_BEEF);
        chk("dual_nw_r3", rd_nw[3], 32'h1234_5678);

        // Collision on r5: slot 0 wins.
        set_w(0, 5'd5, 32'hAAAA_0000, 1'b1);
        set_w(1, 5'd5, 32'h5555_0000, 1'b1);
        ra = {5'd5, 5'd5, 5'd5, 5'd5};
        #3;
        chk("coll_wt", rd_wt[0], 32'hAAAA_0000);
        tick();
        clr_w();
        #3;
        chk("coll_wt_st", rd_wt[1], 32'hAAAA_0000);
        chk("coll_nw_st", rd_nw[1], 32'hAAAA_0000);

        // $0 writes are discarded and never forwarded.
        set_w(0, 5'd0, 32'hCAFE_F00D, 1'b1);
        set_w(1, 5'd0, 32'hCAFE_F00D, 1'b1);
        ra = '0;
        #3;
        chk("r0_same_wt", rd_wt[0], 32'h0);
        tick();
        clr_w();
        #3;
        chk("r0_next_wt", rd_wt[0], 32'h0);
        chk("r0_next_nw", rd_nw[3], 32'h0);

        // HI/LO independent enables, no forwarding.
        hlw = '{wen_h: 1'b1, wen_l: 1'b0, wd_h: 32'h1, wd_l: 32'h99};
        #3;
        chk("hi_no_wt", hi_wt, 32'h0);
        tick();
        hlw = '{wen_h: 1'b0, wen_l: 1'b1, wd_h: 32'h77, wd_l: 32'h2};
        #3;
        chk("hi_set", hi_wt, 32'h1);
        chk("lo_keep", lo_wt, 32'h0);
        tick();
        clr_w();
        #3;
        chk("hi_keep", hi_wt, 32'h1);
        chk("lo_set", lo_wt, 32'h2);

        // Write-through vs. stored-only on r9.
        set_w(1, 5'd9, 32'h11, 1'b1);
        tick();
        set_w(1, 5'd0, 32'h0, 1'b0);
        set_w(0, 5'd9, 32'h42, 1'b1);
        ra = {5'd9, 5'd9, 5'd9, 5'd9};
        #3;
        chk("r9_nw_old", rd_nw[2], 32'h11);
        chk("r9_wt_new", rd_wt[2], 32'h42);
        tick();
        clr_w();
        #3;
        chk("r9_nw_next", rd_nw[2], 32'h42);
        chk("r9_wt_next", rd_wt[2], 32'h42);

        // Mid-stream reset with pending writes, then first write commits.
        reset = 1'b1;
        set_w(0, 5'd12, 32'h5, 1'b1);
        hlw = '{wen_h: 1'b1, wen_l: 1'b1, wd_h: 32'h8, wd_l: 32'h9};
        tick();
        reset = 1'b0;
        clr_w();
        ra = {5'd12, 5'd3, 5'd9, 5'd5};
        #3;
        chk("mid_r12", rd_nw[3], 32'h0);
        chk("mid_r3", rd_nw[2], 32'h0);
        chk("mid_r9", rd_wt[1], 32'h0);
        chk("mid_hi", hi_wt, 32'h0);
        chk("mid_lo", lo_wt, 32'h0);
        set_w(1, 5'd12, 32'h6, 1'b1);
        tick();
        clr_w();
        #3;
        chk("post_r12", rd_nw[3], 32'h6);
        chk("post_r12_wt", rd_wt[3], 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
